wb_spi: RTL and testbench

WB_SPI -- requirements
Module: wb_spi

---
 rtl/wb_spi_pkg.sv | 40 ++++
 rtl/wb_spi_if.sv | 21 ++
 rtl/spi_shift_engine.sv | 92 +++++++++
 rtl/wb_spi.sv | 100 ++++++++++
 tb/tb_wb_spi.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_spi_pkg.sv
// Shared definitions for the Wishbone SPI master: register map, STATUS bits,
// FSM encoding, interconnect placement and a byte-lane merge helper.
package wb_spi_pkg;

    // Word index of each register (address bits [4:2])
    localparam logic [2:0] REG_RXTX    = 3'd0;
    localparam logic [2:0] REG_STATUS  = 3'd1;
    localparam logic [2:0] REG_DIVISOR = 3'd2;
    localparam logic [2:0] REG_CS      = 3'd3;
    localparam logic [2:0] REG_IEN     = 3'd4;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;

    // Placement on the system interconnect
    localparam int unsigned SLAVE_INDEX  = 6;
    localparam logic [14:0] SLAVE_PREFIX = 15'h7003;
    localparam logic [31:0] BASE_ADDR    = 32'hE006_0000;
    localparam int unsigned IRQ_LINE     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

    // Replace only the byte lanes whose select bit is set
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] wdat,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_spi_if.sv
// Wishbone classic slave bus as seen by the SPI master.
interface wb_spi_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_we_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI mode-0 byte engine: phase counter, IDLE/LOW/HIGH FSM, MSB-first shift
// register, received-byte latch and sticky done flag.
module spi_shift_engine
    import wb_spi_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        clr_done,
    input  logic [7:0]  tx_byte,
    input  logic [15:0] divisor,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rx_byte
);

    spi_state_e  state;
    logic [15:0] phase;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        miso_q;
    logic        phase_end;

    // >= rather than == so a smaller divisor written mid-phase cannot strand the counter
    assign phase_end = (phase >= divisor);

    // Phase timing, bit sequencing and shifting in one registered FSM
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state   <= ST_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            miso_q  <= 1'b0;
            sck     <= 1'b0;
            mosi    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            rx_byte <= '0;
        end else begin
            if (clr_done) done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg   <= tx_byte;
                        mosi    <= tx_byte[7];
                        phase   <= '0;
                        bit_idx <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        state   <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (phase_end) begin
                        phase  <= '0;
                        miso_q <= miso;
                        sck    <= 1'b1;
                        state  <= ST_HIGH;
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                ST_HIGH: begin
                    if (phase_end) begin
                        phase <= '0;
                        sck   <= 1'b0;
                        shreg <= {shreg[6:0], miso_q};
                        if (bit_idx == 3'd7) begin
                            rx_byte <= {shreg[6:0], miso_q};
                            busy    <= 1'b0;
                            done    <= 1'b1;   // later assignment: wins over clr_done
                            state   <= ST_IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            mosi    <= shreg[6];
                            state   <= ST_LOW;
                        end
                    end else begin
                        phase <= phase + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/wb_spi.sv
// Wishbone SPI master: register file, single-cycle ack, interrupt, and the
// shift engine instance.
module wb_spi
    import wb_spi_pkg::*;
#(
    parameter int unsigned default_divisor = 24,
    parameter int unsigned cs_width        = 8
) (
    input  logic                clk,
    input  logic                reset,
    wb_spi_if.slave             wb,
    output logic                intr,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso,
    output logic [cs_width-1:0] spi_cs_n
);

    logic [15:0]         divisor;
    logic [cs_width-1:0] cs;
    logic                ien;
    logic                ack_q;
    logic [31:0]         dat_q;
    logic [31:0]         rdata;
    logic                busy;
    logic                done;
    logic [7:0]          rx_byte;
    logic                req, wr, rd, start, clr_done;
    logic [2:0]          idx;
    logic                unused_adr;

    // A request is only seen while no ack is out, giving a one-cycle ack gap
    assign req      = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    assign wr       = req & wb.wb_we_i;
    assign rd       = req & ~wb.wb_we_i;
    assign idx      = wb.wb_adr_i[4:2];
    assign start    = wr && (idx == REG_RXTX) && wb.wb_sel_i[0];
    assign clr_done = req && (idx == REG_RXTX);
    assign unused_adr = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;
    assign spi_cs_n    = ~cs;
    assign intr        = done & ien;

    // Read-data mux over the decoded word index
    always_comb begin
        // NOTE: default first so no path leaves rdata unassigned (no latch).
        rdata = '0;
        case (idx)
            REG_RXTX:    rdata[7:0] = rx_byte;
            REG_STATUS: begin
                rdata[STAT_BUSY] = busy;
                rdata[STAT_DONE] = done;
            end
            REG_DIVISOR: rdata[15:0] = divisor;
            REG_CS:      rdata = 32'(cs);
            REG_IEN:     rdata[0] = ien;
            default:     rdata = '0;
        endcase
    end

    // Bus handshake, read-data capture and register writes
    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            divisor <= 16'(default_divisor);
            cs      <= '0;
            ien     <= 1'b0;
        end else begin
            ack_q <= req;
            dat_q <= rd ? rdata : 32'd0;
            if (wr) begin
                case (idx)
                    REG_DIVISOR: divisor <= 16'(merge_lanes({16'd0, divisor}, wb.wb_dat_i, wb.wb_sel_i));
                    REG_CS:      cs      <= cs_width'(merge_lanes(32'(cs), wb.wb_dat_i, wb.wb_sel_i));
                    REG_IEN:     if (wb.wb_sel_i[0]) ien <= wb.wb_dat_i[0];
                    default:     ;
                endcase
            end
        end
    end

    spi_shift_engine u_engine (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clr_done (clr_done),
        .tx_byte  (wb.wb_dat_i[7:0]),
        .divisor  (divisor),
        .miso     (spi_miso),
        .sck      (spi_sck),
        .mosi     (spi_mosi),
        .busy     (busy),
        .done     (done),
        .rx_byte  (rx_byte)
    );

endmodule

// File: tb/tb_wb_spi.sv
// Self-checking bench for wb_spi: register vector table plus directed
// transfer sequences (loopback, default rate, write-while-busy, interrupt,
// reset mid-transfer).
module tb_wb_spi;
    import wb_spi_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_sck, spi_mosi, spi_miso, intr;
    logic [7:0] spi_cs_n;
    logic       loopback = 1'b1;
    logic       miso_val = 1'b0;
    int         checks = 0;
    int         errors = 0;

    wb_spi_if bus();

    wb_spi #(.default_divisor(24), .cs_width(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .wb       (bus.slave),
        .intr     (intr),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_cs_n (spi_cs_n)
    );

    assign spi_miso = loopback ? spi_mosi : miso_val;

    always #5 clk = ~clk;

    // SCK/busy monitor sampled on the falling edge
    int         sck_rises = 0, busy_cycles = 0, run_len = 1, hi_last = 0, lo_last = 0;
    logic       sck_prev = 1'b0;
    logic [7:0] mosi_hist = 8'h00;

    always @(negedge clk) begin
        if (dut.busy) busy_cycles <= busy_cycles + 1;
        if (spi_sck && !sck_prev) begin
            sck_rises <= sck_rises + 1;
            mosi_hist <= {mosi_hist[6:0], spi_mosi};
        end
        if (spi_sck != sck_prev) begin
            if (sck_prev) hi_last <= run_len;
            else          lo_last <= run_len;
            run_len <= 1;
        end else begin
            run_len <= run_len + 1;
        end
        sck_prev <= spi_sck;
    end

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [31:0] reg_addr(input logic [2:0] i);
        return BASE_ADDR | {27'd0, i, 2'b00};
    endfunction

    function automatic vec_t rd_vec(input logic [2:0] i, input logic [31:0] e);
        vec_t v;
        v.we = 1'b0; v.adr = reg_addr(i); v.dat = '0; v.sel = 4'hF; v.exp = e;
        return v;
    endfunction

    function automatic vec_t wr_vec(input logic [2:0] i, input logic [31:0] d, input logic [3:0] s);
        vec_t v;
        v.we = 1'b1; v.adr = reg_addr(i); v.dat = d; v.sel = s; v.exp = '0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic [31:0] rdata);
        bit got;
        got = 1'b0;
        rdata = '0;
        @(posedge clk); #1;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        bus.wb_we_i  = we;
        bus.wb_stb_i = 1'b1;
        bus.wb_cyc_i = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wb_ack_o) begin
                got = 1'b1;
                rdata = bus.wb_dat_o;
            end
        end
        bus.wb_stb_i = 1'b0;
        bus.wb_cyc_i = 1'b0;
        bus.wb_we_i  = 1'b0;
        check("wb_ack_seen", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_write(input logic [2:0] i, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(1'b1, reg_addr(i), d, 4'hF, dummy);
    endtask

    task automatic wb_read(input logic [2:0] i, output logic [31:0] d);
        wb_access(1'b0, reg_addr(i), '0, 4'hF, d);
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        while (dut.busy && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", {31'd0, dut.busy}, 32'd0);
    endtask

    task automatic wait_rises(input int base, input int target, input int max_cycles);
        int n;
        n = 0;
        while ((sck_rises - base) < target && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        check("sck_rise_reached", 32'(sck_rises - base), 32'(target));
    endtask

    initial begin
        logic [31:0] r;
        int rise_base, busy_base;

        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        bus.wb_we_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0;

        // Reset state of outputs
        repeat (3) @(posedge clk);
        #1;
        check("rst_sck", {31'd0, spi_sck}, 32'd0);
        check("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check("rst_cs_n", {24'd0, spi_cs_n}, 32'hFF);
        check("rst_ack", {31'd0, bus.wb_ack_o}, 32'd0);
        check("rst_dat_o", bus.wb_dat_o, 32'd0);
        check("rst_intr", {31'd0, intr}, 32'd0);
        reset = 1'b0;

        // Register table
        vecs.push_back(rd_vec(REG_STATUS, 32'h0));
        vecs.push_back(rd_vec(REG_DIVISOR, 32'd24));
        vecs.push_back(rd_vec(REG_CS, 32'h0));
        vecs.push_back(rd_vec(REG_IEN, 32'h0));
        vecs.push_back(rd_vec(REG_RXTX, 32'h0));
        vecs.push_back(wr_vec(REG_CS, 32'h0000_0004, 4'b0001));
        vecs.push_back(rd_vec(REG_CS, 32'h4));
        vecs.push_back(rd_vec(3'd5, 32'h0));
        vecs.push_back(wr_vec(3'd5, 32'hFFFF_FFFF, 4'hF));
        vecs.push_back(rd_vec(3'd5, 32'h0));
        vecs.push_back(rd_vec(3'd7, 32'h0));
        vecs.push_back(wr_vec(REG_DIVISOR, 32'h0000_ABCD, 4'b0010));
        vecs.push_back(rd_vec(REG_DIVISOR, 32'h0000_AB18));
        vecs.push_back(wr_vec(REG_DIVISOR, 32'h1234_0005, 4'b0011));
        vecs.push_back(rd_vec(REG_DIVISOR, 32'h5));
        vecs.push_back(wr_vec(REG_STATUS, 32'hFFFF_FFFF, 4'hF));
        vecs.push_back(rd_vec(REG_STATUS, 32'h0));
        vecs.push_back(wr_vec(REG_RXTX, 32'h0000_0055, 4'b0000));
        vecs.push_back(rd_vec(REG_STATUS, 32'h0));
        vecs.push_back(wr_vec(REG_IEN, 32'hFFFF_FFFF, 4'b1110));
        vecs.push_back(rd_vec(REG_IEN, 32'h0));
        vecs.push_back(wr_vec(REG_IEN, 32'h0000_0001, 4'b0001));
        vecs.push_back(rd_vec(REG_IEN, 32'h1));
        vecs.push_back(wr_vec(REG_CS, 32'hFFFF_FF00, 4'b1110));
        vecs.push_back(rd_vec(REG_CS, 32'h4));
        vecs.push_back(wr_vec(REG_IEN, 32'h0, 4'b0001));

        rise_base = sck_rises;
        foreach (vecs[i]) begin
            wb_access(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r);
            check($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, bus.wb_ack_o}, 32'd0);
        check("dat_o_idle_zero", bus.wb_dat_o, 32'd0);
        check("cs_n_after_cs4", {24'd0, spi_cs_n}, 32'hFB);
        check("sel0_no_transfer", 32'(sck_rises - rise_base), 32'd0);

        // Loopback at DIVISOR=0
        loopback = 1'b1;
        wb_write(REG_DIVISOR, 32'd0);
        rise_base = sck_rises;
        busy_base = busy_cycles;
        wb_write(REG_RXTX, 32'hA5);
        wait_idle(100);
        check("lb_busy_cycles", 32'(busy_cycles - busy_base), 32'd16);
        check("lb_sck_pulses", 32'(sck_rises - rise_base), 32'd8);
        check("lb_sck_hi", 32'(hi_last), 32'd1);
        check("lb_sck_lo", 32'(lo_last), 32'd1);
        wb_read(REG_STATUS, r);
        check("lb_status_done", r, 32'h2);
        wb_read(REG_RXTX, r);
        check("lb_rx", r, 32'hA5);
        wb_read(REG_STATUS, r);
        check("lb_done_cleared", r, 32'h0);

        // Write while busy is acked but ignored
        wb_write(REG_DIVISOR, 32'd3);
        rise_base = sck_rises;
        busy_base = busy_cycles;
        wb_write(REG_RXTX, 32'h12);
        wait_rises(rise_base, 4, 200);
        wb_write(REG_RXTX, 32'hFF);
        wait_idle(200);
        check("wwb_sck_pulses", 32'(sck_rises - rise_base), 32'd8);
        check("wwb_busy_cycles", 32'(busy_cycles - busy_base), 32'd64);
        wb_read(REG_RXTX, r);
        check("wwb_rx", r, 32'h12);

        // Interrupt
        wb_write(REG_IEN, 32'd1);
        wb_write(REG_DIVISOR, 32'd0);
        wb_write(REG_RXTX, 32'h5A);
        check("irq_low_during", {31'd0, intr}, 32'd0);
        wait_idle(100);
        check("irq_set", {31'd0, intr}, 32'd1);
        wb_read(REG_RXTX, r);
        check("irq_rx", r, 32'h5A);
        check("irq_cleared", {31'd0, intr}, 32'd0);

        // Reset mid-transfer
        wb_write(REG_DIVISOR, 32'd2);
        wb_write(REG_CS, 32'h81);
        rise_base = sck_rises;
        wb_write(REG_RXTX, 32'hF0);
        wait_rises(rise_base, 5, 200);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_sck", {31'd0, spi_sck}, 32'd0);
        check("rstmid_cs_n", {24'd0, spi_cs_n}, 32'hFF);
        check("rstmid_busy", {31'd0, dut.busy}, 32'd0);
        check("rstmid_done", {31'd0, dut.done}, 32'd0);
        check("rstmid_intr", {31'd0, intr}, 32'd0);
        reset = 1'b0;
        wb_read(REG_DIVISOR, r);
        check("rstmid_divisor", r, 32'd24);
        wb_read(REG_STATUS, r);
        check("rstmid_status", r, 32'h0);
        wb_read(REG_RXTX, r);
        check("rstmid_rx", r, 32'h0);

        // Default divisor, MISO held high
        loopback = 1'b0;
        miso_val = 1'b1;
        rise_base = sck_rises;
        busy_base = busy_cycles;
        wb_write(REG_RXTX, 32'h3C);
        wait_idle(1000);
        check("def_busy_cycles", 32'(busy_cycles - busy_base), 32'd400);
        check("def_sck_pulses", 32'(sck_rises - rise_base), 32'd8);
        check("def_sck_hi", 32'(hi_last), 32'd25);
        check("def_sck_lo", 32'(lo_last), 32'd25);
        check("def_mosi_bits", {24'd0, mosi_hist}, 32'h3C);
        wb_read(REG_RXTX, r);
        check("def_rx", r, 32'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
